// File: rtl/fetch_sequencer.sv
// Program-counter sequencer with fetch handshake, execute stall, and
// flag-conditional jump/call/return backed by a circular link stack.
module fetch_sequencer #(
  parameter int               WIDTH       = 32,
  parameter int               STACK_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  output logic [WIDTH-1:0]               pc,
  output logic                           inst_req,
  input  logic                           inst_ack,
  input  logic                           stall,
  input  logic                           br_valid,
  input  logic [1:0]                     br_op,
  input  logic [2:0]                     br_cond,
  input  logic [2:0]                     flags,
  input  logic [WIDTH-1:0]               br_target,
  input  logic [WIDTH-1:0]               br_link,
  output logic                           taken,
  output logic [$clog2(STACK_DEPTH):0]   sp,
  output logic                           stack_ovf,
  output logic                           stack_udf
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = PTR_W + 1;

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_HOLD} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_inst_req;

  logic [WIDTH-1:0] r_stack [STACK_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [SP_W-1:0]  r_sp;
  logic             r_ovf;
  logic             r_udf;

  logic             w_cond_met;
  logic             w_eligible;
  logic             w_is_call;
  logic             w_is_ret;
  logic             w_empty;
  logic             w_full;
  logic             w_taken;
  logic             w_push;
  logic             w_pop;
  logic             w_udf_evt;
  logic [PTR_W-1:0] w_top_idx;
  logic [WIDTH-1:0] w_dest;

  assign w_cond_met = (br_cond == 3'b000) || (br_cond == flags);
  // Reset and BOOT both mask the branch port entirely.
  assign w_eligible = rst && (r_state != S_BOOT) && br_valid && w_cond_met && (br_op != 2'b11);
  assign w_is_call  = (br_op == 2'b01);
  assign w_is_ret   = (br_op == 2'b10);
  assign w_empty    = (r_sp == '0);
  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_taken    = w_eligible && !(w_is_ret && w_empty);
  assign w_push     = w_taken && w_is_call;
  assign w_pop      = w_taken && w_is_ret;
  assign w_udf_evt  = w_eligible && w_is_ret && w_empty;
  assign w_top_idx  = r_wr_ptr - PTR_W'(1);
  assign w_dest     = w_is_ret ? r_stack[w_top_idx] : br_target;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_inst_req   = 1'b0;
    case (r_state)
      S_BOOT: w_state_next = S_FETCH;
      S_FETCH: begin
        w_inst_req = 1'b1;
        if (inst_ack) begin
          if (stall) w_state_next = S_HOLD;
          else       w_pc_next    = r_pc + WIDTH'(1);
        end
      end
      S_HOLD: begin
        if (!stall) begin
          w_pc_next    = r_pc + WIDTH'(1);
          w_state_next = S_FETCH;
        end
      end
      default: w_state_next = S_BOOT;
    endcase
    if (w_taken) begin
      w_pc_next    = w_dest;
      w_state_next = S_FETCH;
    end
  end

  // Write pointer marks the next free slot; when full it lands on the oldest entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_sp     <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_full) r_ovf <= 1'b1;
        else        r_sp  <= r_sp + SP_W'(1);
      end else if (w_pop) begin
        r_wr_ptr <= w_top_idx;
        r_sp     <= r_sp - SP_W'(1);
      end
      if (w_udf_evt) r_udf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_wr_ptr] <= br_link;
  end

  assign pc        = r_pc;
  assign inst_req  = w_inst_req;
  assign taken     = w_taken;
  assign sp        = r_sp;
  assign stack_ovf = r_ovf;
  assign stack_udf = r_udf;

endmodule
